// File: rtl/rfdc_dds_sequencer_if.sv
// Command stream into the DDS sequencer: 160-bit timed parameter commands with valid/ready handshake.
interface rfdc_dds_sequencer_if;
  logic [159:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/rfdc_dds_sequencer.sv
// Timed-command sequencer for the 16-sample/clk RFDC DDS: master timestamp plus FWFT command queue.
// Optional build macro SEQ_LATE_DROP_EN: late commands are discarded instead of applied.
module rfdc_dds_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          run,
  input  logic                          ts_clear,
  rfdc_dds_sequencer_if.slave           s_axis,
  output logic [63:0]                   timestamp,
  output logic [47:0]                   freq,
  output logic [13:0]                   amp,
  output logic [13:0]                   phase,
  output logic [13:0]                   amp_offset,
  output logic [63:0]                   time_offset,
  output logic                          late_pulse,
  output logic [CNT_W-1:0]              late_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  // Packed so that it overlays tdata[154:0] bit-for-bit.
  typedef struct packed {
    logic        phase_sync;
    logic [13:0] amp_offset;
    logic [13:0] phase;
    logic [13:0] amp;
    logic [47:0] freq;
    logic [63:0] cmd_time;
  } cmd_t;

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             cmd_in;
  cmd_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count, count_nxt;
  logic             tready_q;
  logic             head_valid;
  logic [59:0]      head_t;
  logic [63:0]      ts_next;
  logic             push, pop, late, apply, load;
  logic             unused_rsvd;

  assign cmd_in      = cmd_t'(s_axis.tdata[154:0]);
  assign unused_rsvd = ^s_axis.tdata[159:155];
  assign s_axis.tready = tready_q;

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);
  assign head_t     = head.cmd_time[63:4];
  assign push       = s_axis.tvalid && tready_q;

  always_comb begin
    ts_next = timestamp;
    if (ts_clear)  ts_next = '0;
    else if (run)  ts_next = timestamp + 64'd16;
  end

  // A ts_clear cycle neither applies nor flags late; the queue simply waits.
  always_comb begin
    late  = head_valid && !ts_clear && (head_t <= timestamp[63:4]);
    apply = head_valid && !ts_clear && !late && (ts_next[63:4] == head_t);
    pop   = apply || late;
`ifdef SEQ_LATE_DROP_EN
    load  = apply;
`else
    load  = apply || late;
`endif
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; discarding the queue only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      // Registered !full: a pop in a full cycle cannot reopen tready until the next edge.
      tready_q <= (count_nxt != LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timestamp   <= '0;
      freq        <= '0;
      amp         <= '0;
      phase       <= '0;
      amp_offset  <= '0;
      time_offset <= '0;
      late_pulse  <= 1'b0;
      late_count  <= '0;
    end else begin
      timestamp  <= ts_next;
      late_pulse <= late;
      if (late && (late_count != '1)) late_count <= late_count + 1'b1;
      if (load) begin
        freq       <= head.freq;
        amp        <= head.amp;
        phase      <= head.phase;
        amp_offset <= head.amp_offset;
        if (head.phase_sync) time_offset <= {head_t, 4'b0000};
      end
    end
  end

  assign fifo_level = count;

endmodule

// File: tb/tb_rfdc_dds_sequencer.sv
// Directed bench for rfdc_dds_sequencer with a scoreboard of expected parameter updates keyed by timestamp.
module tb_rfdc_dds_sequencer;

  logic        clk = 1'b0;
  logic        resetn, run, ts_clear;
  logic [63:0] timestamp, time_offset;
  logic [47:0] freq;
  logic [13:0] amp, phase, amp_offset;
  logic        late_pulse;
  logic [15:0] late_count;
  logic [4:0]  fifo_level;

  rfdc_dds_sequencer_if axis ();

  rfdc_dds_sequencer #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .run(run), .ts_clear(ts_clear),
    .s_axis(axis),
    .timestamp(timestamp), .freq(freq), .amp(amp), .phase(phase),
    .amp_offset(amp_offset), .time_offset(time_offset),
    .late_pulse(late_pulse), .late_count(late_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] t;
    logic [47:0] f;
    logic [13:0] a, p, ao;
    logic [63:0] to;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_toff;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; retire a scoreboard entry when its time is reached.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0 && timestamp == sb[0].t) begin
      e = sb.pop_front();
      chk("sb_freq",  freq,        e.f);
      chk("sb_amp",   amp,         e.a);
      chk("sb_phase", phase,       e.p);
      chk("sb_aoff",  amp_offset,  e.ao);
      chk("sb_toff",  time_offset, e.to);
    end
  endtask

  task automatic wait_ts(input logic [63:0] tgt, input int budget);
    int n = 0;
    while (timestamp != tgt && n < budget) begin
      tick();
      n++;
    end
    chk("wait_ts", timestamp, tgt);
  endtask

  function automatic logic [159:0] pack(input logic [63:0] t, input logic [47:0] f,
                                        input logic [13:0] a, input logic [13:0] p,
                                        input logic [13:0] ao, input logic ps);
    return {5'h15, ps, ao, p, a, f, t};
  endfunction

  task automatic send(input logic [63:0] t, input logic [47:0] f, input logic [13:0] a,
                      input logic [13:0] p, input logic [13:0] ao, input logic ps,
                      input bit expect_apply);
    logic acc = 1'b0;
    int   n   = 0;
    if (expect_apply) begin
      if (ps) m_toff = {t[63:4], 4'b0000};
      sb.push_back('{t: {t[63:4], 4'b0000}, f: f, a: a, p: p, ao: ao, to: m_toff});
    end
    axis.tdata  = pack(t, f, a, p, ao, ps);
    axis.tvalid = 1'b1;
    while (!acc && n < 50) begin
      acc = axis.tready;
      tick();
      n++;
    end
    axis.tvalid = 1'b0;
    chk("send_accept", {63'd0, acc}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] amp_prev;
    logic [47:0] freq_prev;
    m_toff      = '0;
    resetn      = 1'b0;
    run         = 1'b0;
    ts_clear    = 1'b0;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;

    // Reset state
    tick(); tick();
    chk("rst_ts",     timestamp, 0);
    chk("rst_freq",   freq, 0);
    chk("rst_amp",    amp, 0);
    chk("rst_toff",   time_offset, 0);
    chk("rst_late",   late_count, 0);
    chk("rst_level",  fifo_level, 0);
    chk("rst_tready", axis.tready, 0);

    // Release and free-run 4 clocks
    resetn = 1'b1;
    run    = 1'b1;
    chk("rel_tready_pre", axis.tready, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("run_ts", timestamp, 64'(16 * i));
      chk("run_tready", axis.tready, 1);
    end
    run = 1'b0;
    chk("run_freq", freq, 0);
    chk("run_amp", amp, 0);
    chk("run_lpulse", late_pulse, 0);

    // Single command at 0x100
    ts_clear = 1'b1; tick(); ts_clear = 1'b0;
    chk("clr_ts", timestamp, 0);
    send(64'h100, 48'h1234, 14'd0, 14'd0, 14'd0, 1'b0, 1'b1);
    chk("one_level1", fifo_level, 1);
    run = 1'b1;
    wait_ts(64'hF0, 100);
    chk("one_freq_before", freq, 0);
    chk("one_level_before", fifo_level, 1);
    tick();
    chk("one_ts", timestamp, 64'h100);
    chk("one_freq", freq, 48'h1234);
    chk("one_level0", fifo_level, 0);

    // Back-to-back commands
    send(64'h200, 48'h1234, 14'd1, 14'd0, 14'd0, 1'b0, 1'b1);
    send(64'h210, 48'h1234, 14'd2, 14'd0, 14'd0, 1'b0, 1'b1);
    send(64'h220, 48'h1234, 14'd3, 14'd0, 14'd0, 1'b0, 1'b1);
    wait_ts(64'h200, 100);
    chk("b2b_amp1", amp, 1);
    tick(); chk("b2b_amp2", amp, 2);
    tick(); chk("b2b_amp3", amp, 3);
    chk("b2b_sb_empty", sb.size(), 0);

    // Late command: 0x40 while timestamp held at 0x80
    run = 1'b0;
    ts_clear = 1'b1; tick(); ts_clear = 1'b0;
    run = 1'b1;
    wait_ts(64'h80, 20);
    run = 1'b0;
    amp_prev  = amp;
    freq_prev = freq;
    send(64'h40, 48'h777, 14'h155, 14'd9, 14'd5, 1'b0, 1'b0);
    chk("late_pulse_pre", late_pulse, 0);
    chk("late_level_pre", fifo_level, 1);
    tick();
    chk("late_pulse", late_pulse, 1);
    chk("late_count", late_count, 1);
    chk("late_level", fifo_level, 0);
`ifdef SEQ_LATE_DROP_EN
    chk("late_amp", amp, amp_prev);
    chk("late_freq", freq, freq_prev);
`else
    chk("late_amp", amp, 14'h155);
    chk("late_freq", freq, 48'h777);
`endif
    tick();
    chk("late_pulse_end", late_pulse, 0);
    chk("late_count_hold", late_count, 1);
    chk("late_ts_hold", timestamp, 64'h80);

    // Fill the queue with run = 0
    for (int i = 0; i < 16; i++)
      send(64'h1000 + 64'(16 * i), 48'(i + 16), 14'(i + 100), 14'(i), 14'(i + 7), 1'b0, 1'b1);
    chk("full_tready", axis.tready, 0);
    chk("full_level", fifo_level, 16);
    axis.tdata  = pack(64'h9000, 48'hDEAD, 14'd1, 14'd1, 14'd1, 1'b0);
    axis.tvalid = 1'b1;
    tick(); tick();
    axis.tvalid = 1'b0;
    chk("full_17th_level", fifo_level, 16);
    ts_clear = 1'b1; tick(); ts_clear = 1'b0;
    chk("full_clr_ts", timestamp, 0);
    chk("full_clr_level", fifo_level, 16);
    run = 1'b1;
    wait_ts(64'h10F0, 400);
    chk("full_drained", fifo_level, 0);
    chk("full_sb_empty", sb.size(), 0);
    chk("full_late_none", late_count, 1);

    // phase_sync, then reset with commands queued
    run = 1'b0;
    ts_clear = 1'b1; tick(); ts_clear = 1'b0;
    send(64'h300, 48'hABCDE, 14'd7, 14'h2A, 14'h11, 1'b1, 1'b1);
    run = 1'b1;
    wait_ts(64'h300, 100);
    chk("psync_toff", time_offset, 64'h300);
    chk("psync_sb_empty", sb.size(), 0);
    send(64'h400, 48'h55, 14'd9, 14'd9, 14'd9, 1'b1, 1'b0);
    send(64'h500, 48'h66, 14'd8, 14'd8, 14'd8, 1'b0, 1'b0);
    chk("mid_level", fifo_level, 2);
    resetn = 1'b0;
    #1;
    chk("mid_rst_ts", timestamp, 0);
    chk("mid_rst_freq", freq, 0);
    chk("mid_rst_amp", amp, 0);
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_aoff", amp_offset, 0);
    chk("mid_rst_toff", time_offset, 0);
    chk("mid_rst_late", late_count, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_tready", axis.tready, 0);
    m_toff = '0;
    tick();
    resetn = 1'b1;
    tick();
    chk("post_tready", axis.tready, 1);
    wait_ts(64'h510, 200);
    chk("post_freq", freq, 0);
    chk("post_toff", time_offset, 0);
    chk("post_level", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
